// File: rtl/input_quantizer_loader.sv
// rtl/input_quantizer_loader.sv - quantizes a raw feature stream and packs full frames for layer 0
// Optional QUANT_CLIP_STATS_EN adds a saturating clip_count of high-clipped features.
module input_quantizer_loader #(
  parameter int NUM_FEATURES = 16,
  parameter int IN_WIDTH     = 8,
  parameter int OUT_BITS     = 2,
  parameter int SHIFT        = 6,
  parameter int OFFSET       = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [IN_WIDTH-1:0]            s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_FEATURES*OUT_BITS-1:0] m_data,
  output logic                           err_frame
`ifdef QUANT_CLIP_STATS_EN
  ,output logic [15:0]                   clip_count
`endif
);

  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam int MW    = NUM_FEATURES * OUT_BITS;
  localparam logic [IN_WIDTH-1:0] OFF_W    = IN_WIDTH'(OFFSET);
  localparam logic [IN_WIDTH-1:0] CODE_MAX = IN_WIDTH'((1 << OUT_BITS) - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_FEATURES - 1);
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]          state;
  logic [IDX_W-1:0]    idx;
  logic [MW-1:0]       asm_q;
  logic [MW-1:0]       asm_next;
  logic [IN_WIDTH:0]   diff;
  logic [IN_WIDTH-1:0] q;
  logic                clipped;
  logic [OUT_BITS-1:0] code;
  logic                accept, at_end, complete, len_err, out_free;

  // Extra borrow bit detects s_data < OFFSET without a signed compare.
  always_comb begin
    diff    = {1'b0, s_data} - {1'b0, OFF_W};
    q       = diff[IN_WIDTH] ? '0 : (diff[IN_WIDTH-1:0] >> SHIFT);
    clipped = (q > CODE_MAX);
    code    = clipped ? {OUT_BITS{1'b1}} : q[OUT_BITS-1:0];
  end

  assign s_ready  = (state == ST_FILL) && !rst;
  assign accept   = s_valid && s_ready;
  assign at_end   = (idx == LAST_IDX);
  assign complete = accept && s_last && at_end;
  assign len_err  = accept && (s_last ^ at_end);
  assign out_free = !m_valid || m_ready;

  always_comb begin
    asm_next = asm_q;
    asm_next[idx*OUT_BITS +: OUT_BITS] = code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FILL;
      idx       <= '0;
      asm_q     <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      err_frame <= 1'b0;
    end else begin
      err_frame <= len_err;
      if (m_ready) m_valid <= 1'b0;
      if (accept) asm_q <= asm_next;
      if (state == ST_FILL) begin
        if (complete) begin
          if (out_free) begin
            m_data  <= asm_next;
            m_valid <= 1'b1;
            idx     <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end else if (len_err) begin
          idx <= '0;
        end else if (accept) begin
          idx <= idx + 1'b1;
        end
      end else if (out_free) begin
        m_data  <= asm_q;
        m_valid <= 1'b1;
        idx     <= '0;
        state   <= ST_FILL;
      end
    end
  end

`ifdef QUANT_CLIP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_count <= '0;
    end else if (accept && clipped && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_input_quantizer_loader.sv
// tb/tb_input_quantizer_loader.sv - directed self-checking bench for input_quantizer_loader
module tb_input_quantizer_loader;

  logic       clk = 1'b0;
  logic       rst, s_valid, s_last, m_ready;
  logic [7:0] s_data;
  logic       s_ready, m_valid, err_frame;
  logic [7:0] m_data;
  logic       s_ready2, m_valid2, err_frame2;
  logic [7:0] m_data2;
`ifdef QUANT_CLIP_STATS_EN
  logic [15:0] clip_count, clip_count2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_quantizer_loader #(.NUM_FEATURES(4), .IN_WIDTH(8), .OUT_BITS(2), .SHIFT(6), .OFFSET(0)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_frame(err_frame)
`ifdef QUANT_CLIP_STATS_EN
    , .clip_count(clip_count)
`endif
  );

  input_quantizer_loader #(.NUM_FEATURES(4), .IN_WIDTH(8), .OUT_BITS(2), .SHIFT(5), .OFFSET(32)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .err_frame(err_frame2)
`ifdef QUANT_CLIP_STATS_EN
    , .clip_count(clip_count2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int pulses;
    int prev_at;
    int accepts;

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_err", err_frame, 0);
`ifdef QUANT_CLIP_STATS_EN
    chk("rst_clip", clip_count2, 0);
`endif
    rst = 1'b0; #1;
    chk("post_rst_s_ready", s_ready, 1);

    // Basic quantization, output free
    m_ready = 1'b1;
    send(8'h00, 1'b0); send(8'h40, 1'b0); send(8'h80, 1'b0);
    chk("t1_no_valid_early", m_valid, 0);
    send(8'hFF, 1'b1);
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_data", m_data, 8'hE4);
    chk("t1_m_data2", m_data2, 8'hF4);
    idle(1);
    chk("t1_valid_clear", m_valid, 0);

    // Offset path: codes 0,0,1,3 at slots 0..3
    send_frame(8'h10, 8'h20, 8'h5F, 8'hFF);
    chk("t2_m_data2", m_data2, 8'hD0);
    chk("t2_m_data", m_data, 8'hD0);
`ifdef QUANT_CLIP_STATS_EN
    chk("t2_clip2", clip_count2, 2);
    chk("t2_clip", clip_count, 0);
`endif
    idle(1);

    // Backpressure into WAIT
    m_ready = 1'b0;
    send_frame(8'hC0, 8'h80, 8'h40, 8'h00);
    chk("t3_a_valid", m_valid, 1);
    chk("t3_a_data", m_data, 8'h1B);
    chk("t3_a_ready", s_ready, 1);
    send_frame(8'h00, 8'h00, 8'h40, 8'h80);
    chk("t3_wait_ready", s_ready, 0);
    chk("t3_hold_data", m_data, 8'h1B);
    idle(1);
    chk("t3_hold_valid", m_valid, 1);
    chk("t3_hold_data2", m_data, 8'h1B);
    m_ready = 1'b1;
    idle(1);
    chk("t3_b_valid", m_valid, 1);
    chk("t3_b_data", m_data, 8'h90);
    chk("t3_b_ready", s_ready, 1);
    idle(1);
    chk("t3_b_drained", m_valid, 0);

    // Completion with simultaneous drain of an occupied register
    m_ready = 1'b0;
    send_frame(8'h00, 8'h40, 8'h80, 8'hFF);
    send(8'hC0, 1'b0); send(8'h80, 1'b0); send(8'h40, 1'b0);
    m_ready = 1'b1;
    send(8'h00, 1'b1);
    chk("t3s_valid", m_valid, 1);
    chk("t3s_data", m_data, 8'h1B);
    chk("t3s_ready", s_ready, 1);
    idle(1);
    chk("t3s_drained", m_valid, 0);

    // Early s_last
    send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b1);
    chk("t4_err_pulse", err_frame, 1);
    chk("t4_no_valid", m_valid, 0);
    idle(1);
    chk("t4_err_clear", err_frame, 0);
    send_frame(8'hFF, 8'h00, 8'h00, 8'h40);
    chk("t4_recover_valid", m_valid, 1);
    chk("t4_recover_data", m_data, 8'h43);
    chk("t4_recover_err", err_frame, 0);
    idle(1);
    // Missing s_last
    send(8'h40, 1'b0); send(8'h40, 1'b0); send(8'h40, 1'b0); send(8'h40, 1'b0);
    chk("t4b_err_pulse", err_frame, 1);
    chk("t4b_no_valid", m_valid, 0);
    idle(1);

    // Reset while in WAIT
    m_ready = 1'b0;
    send_frame(8'h00, 8'h40, 8'h80, 8'hFF);
    send_frame(8'hC0, 8'h80, 8'h40, 8'h00);
    chk("t5_in_wait", s_ready, 0);
    chk("t5_valid", m_valid, 1);
    rst = 1'b1; #1;
    chk("t5_rst_ready_pre", s_ready, 0);
    @(posedge clk); #1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_data", m_data, 8'h00);
    chk("t5_rst_ready", s_ready, 0);
    rst = 1'b0; #1;
    chk("t5_ready_after", s_ready, 1);
    m_ready = 1'b1;
    send_frame(8'hFF, 8'h80, 8'h40, 8'h00);
    chk("t5_fresh_valid", m_valid, 1);
    chk("t5_fresh_data", m_data, 8'h1B);
    idle(1);

    // Three back-to-back frames with m_ready high
    pulses = 0; prev_at = -1; accepts = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 12) begin
        s_valid = 1'b1;
        s_data  = (c % 4 == 0) ? 8'h00 : (c % 4 == 1) ? 8'h40 : (c % 4 == 2) ? 8'h80 : 8'hFF;
        s_last  = (c % 4 == 3);
        if (s_ready) accepts++;
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      @(posedge clk); #1;
      if (m_valid) begin
        pulses++;
        chk("t6_data", m_data, 8'hE4);
        if (prev_at >= 0) chk("t6_spacing", c - prev_at, 4);
        else chk("t6_first_at", c, 3);
        prev_at = c;
      end
    end
    chk("t6_accepts", accepts, 12);
    chk("t6_pulses", pulses, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
